// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - fetch port, load byte stream and loader status bundle for imem_loader
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [31:0]     pc_in;
    logic [31:0]     inst_out;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic            load_start;
    logic            cpu_hold;
    logic            load_busy;
    logic            load_done;
    logic            load_err;
    logic [ADDR_W:0] words_loaded;

    modport master (
        output pc_in, rx_data, rx_valid, load_start,
        input  inst_out, rx_ready, cpu_hold, load_busy, load_done, load_err, words_loaded
    );

    modport slave (
        input  pc_in, rx_data, rx_valid, load_start,
        output inst_out, rx_ready, cpu_hold, load_busy, load_done, load_err, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory with framed byte-stream loader; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum word
module imem_loader #(
    parameter int          ADDR_W      = 10,
    parameter int          TIMEOUT_CYC = 1000000,
    parameter logic [31:0] NOP_INST    = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_HDR,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    logic [31:0]     mem [DEPTH];

    state_t          state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [23:0]     shift_q, shift_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [ADDR_W:0] widx_q, widx_d;
    logic [31:0]     idle_q, idle_d;
    logic            err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]     sum_q, sum_d;
`endif

    logic            in_load;
    logic            rx_ready;
    logic            accept;
    logic            word_done;
    logic [31:0]     full_word;
    logic            mem_we;
    logic            unused_pc;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_load = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
    assign in_load = (state_q == S_HDR) || (state_q == S_DATA);
`endif
    assign rx_ready  = in_load && !bus.load_start;
    assign accept    = bus.rx_valid && rx_ready;
    assign word_done = accept && (byte_cnt_q == 2'd3);
    assign full_word = {bus.rx_data, shift_q};

    // Loader FSM: byte assembly, frame parsing, timeout and error/done sequencing
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        widx_d     = widx_q;
        idle_d     = idle_q;
        err_d      = err_q;
        mem_we     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        if (bus.load_start && (state_q != S_DONE) && (state_q != S_ERR)) begin
            // Start or restart: every per-load counter begins from zero
            state_d    = S_HDR;
            err_d      = 1'b0;
            widx_d     = '0;
            byte_cnt_d = '0;
            shift_d    = '0;
            idle_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d      = '0;
`endif
        end else begin
            case (state_q)
                S_DONE:  state_d = S_RUN;
                S_ERR:   state_d = S_HOLD;
                S_HOLD, S_RUN: state_d = state_q;
                default: begin
                    if (accept) begin
                        idle_d     = '0;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0:    shift_d[7:0]   = bus.rx_data;
                            2'd1:    shift_d[15:8]  = bus.rx_data;
                            2'd2:    shift_d[23:16] = bus.rx_data;
                            default: shift_d        = shift_q;
                        endcase
                        if (word_done) begin
                            if (state_q == S_HDR) begin
                                if ((full_word == 32'd0) || (full_word > 32'(DEPTH))) begin
                                    state_d = S_ERR;
                                end else begin
                                    len_d   = full_word[ADDR_W:0];
                                    state_d = S_DATA;
                                end
                            end else if (state_q == S_DATA) begin
                                mem_we = 1'b1;
                                widx_d = widx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                                sum_d  = sum_q + full_word;
                                if (widx_d == len_q) state_d = S_CSUM;
`else
                                if (widx_d == len_q) state_d = S_DONE;
`endif
                            end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_d = (full_word == sum_q) ? S_DONE : S_ERR;
`endif
                            end
                        end
                    end else begin
                        idle_d = idle_q + 32'd1;
                        if ((TIMEOUT_CYC != 0) && (idle_q == 32'(TIMEOUT_CYC - 1))) begin
                            state_d = S_ERR;
                        end
                    end
                end
            endcase
        end
        if (state_d == S_ERR) err_d = 1'b1;
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HOLD;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            widx_q     <= '0;
            idle_q     <= '0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            widx_q     <= widx_d;
            idle_q     <= idle_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // Memory write port; contents survive reset, a word only lands once all 4 bytes arrived
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[widx_q[ADDR_W-1:0]] <= full_word;
    end

    assign unused_pc        = ^bus.pc_in[1:0];
    assign bus.inst_out     = (|bus.pc_in[31:ADDR_W+2]) ? NOP_INST : mem[bus.pc_in[ADDR_W+1:2]];
    assign bus.rx_ready     = rx_ready;
    assign bus.cpu_hold     = (state_q != S_RUN);
    assign bus.load_busy    = in_load || (state_q == S_DONE);
    assign bus.load_done    = (state_q == S_DONE);
    assign bus.load_err     = err_q;
    assign bus.words_loaded = widx_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;
    localparam int          AW    = 6;
    localparam int          DEPTH = 1 << AW;
    localparam int          TO    = 16;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(AW)) bus();

    imem_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO), .NOP_INST(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit is_err;
        int words;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk    = 0;
    int  n_fail   = 0;
    bit  err_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input bit is_err, input int words);
        ev_t e;
        e.is_err = is_err;
        e.words  = words;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.rx_ready) break;
            n++;
            if (n > 50) begin
                n_chk++;
                n_fail++;
                $display("FAIL rx_ready_wait: got no ready within 50 cycles expected ready");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.load_start = 1'b1;
        @(posedge clk);
        #1 bus.load_start = 1'b0;
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] pc, input logic [31:0] exp);
        bus.pc_in = pc;
        #1;
        chk(name, bus.inst_out, exp);
    endtask

    // Completion/error monitor: each load_done pulse or load_err rise consumes one expected event
    always @(negedge clk) begin
        if (!rst && (bus.load_done || (bus.load_err && !err_prev))) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL event: got err=%0d words=%0d expected no event", bus.load_err, bus.words_loaded);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ((e.is_err != bus.load_err) || (e.words != int'(bus.words_loaded))) begin
                    n_fail++;
                    $display("FAIL event: got err=%0d words=%0d expected err=%0d words=%0d",
                             bus.load_err, bus.words_loaded, e.is_err, e.words);
                end
            end
        end
        err_prev = bus.load_err;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pc_in      = '0;
        bus.rx_data    = '0;
        bus.rx_valid   = 1'b0;
        bus.load_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_cpu_hold", 32'(bus.cpu_hold), 1);
        chk("rst_rx_ready", 32'(bus.rx_ready), 0);
        chk("rst_busy", 32'(bus.load_busy), 0);
        chk("rst_done", 32'(bus.load_done), 0);
        chk("rst_err", 32'(bus.load_err), 0);
        chk("rst_words", 32'(bus.words_loaded), 0);
        fetch_chk("nop_oor", 32'h0001_0000, NOP);

        // Basic two-word load
        expect_ev(1'b0, 2);
        pulse_start();
        chk("hdr_busy", 32'(bus.load_busy), 1);
        send_word(32'd2);
        send_word(32'h00500093);
        send_word(32'h00A00113);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h00F001A6);
`endif
        chk("done_hold", 32'(bus.cpu_hold), 1);
        chk("done_pulse", 32'(bus.load_done), 1);
        cycles(1);
        chk("run_hold", 32'(bus.cpu_hold), 0);
        chk("run_busy", 32'(bus.load_busy), 0);
        chk("run_words", 32'(bus.words_loaded), 2);
        fetch_chk("pc0", 32'h0, 32'h00500093);
        fetch_chk("pc4", 32'h4, 32'h00A00113);
        fetch_chk("pc5_lowbits", 32'h5, 32'h00A00113);
        fetch_chk("pc_depth_oor", 32'(DEPTH * 4), NOP);

        // Reset keeps memory, returns to HOLD
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst2_hold", 32'(bus.cpu_hold), 1);
        fetch_chk("rst2_mem", 32'h0, 32'h00500093);

        // LEN = 0
        expect_ev(1'b1, 0);
        pulse_start();
        send_word(32'd0);
        cycles(3);
        chk("len0_err", 32'(bus.load_err), 1);
        chk("len0_hold", 32'(bus.cpu_hold), 1);
        chk("len0_ready", 32'(bus.rx_ready), 0);
        chk("len0_busy", 32'(bus.load_busy), 0);
        fetch_chk("len0_mem", 32'h0, 32'h00500093);

        // LEN = DEPTH + 1
        expect_ev(1'b1, 0);
        pulse_start();
        chk("restart_clears_err", 32'(bus.load_err), 0);
        send_word(32'(DEPTH + 1));
        cycles(3);
        chk("lenbig_err", 32'(bus.load_err), 1);
        chk("lenbig_hold", 32'(bus.cpu_hold), 1);
        fetch_chk("lenbig_mem", 32'h0, 32'h00500093);

        // LEN = DEPTH fills the whole memory
        expect_ev(1'b0, DEPTH);
        pulse_start();
        send_word(32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) send_word(32'h1000_0000 + 32'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h000007E0);
`endif
        cycles(2);
        chk("full_words", 32'(bus.words_loaded), DEPTH);
        chk("full_hold", 32'(bus.cpu_hold), 0);
        fetch_chk("full_last", 32'((DEPTH - 1) * 4), 32'h1000_003F);
        fetch_chk("full_first", 32'h0, 32'h1000_0000);

        // Timeout after 5 bytes
        expect_ev(1'b1, 0);
        pulse_start();
        send_word(32'd2);
        send_byte(8'h55);
        cycles(TO - 1);
        chk("to_not_yet", 32'(bus.load_err), 0);
        cycles(1);
        chk("to_err", 32'(bus.load_err), 1);
        cycles(2);
        chk("to_hold", 32'(bus.cpu_hold), 1);

        // Mid-DATA abort with a byte presented alongside load_start
        expect_ev(1'b0, 1);
        pulse_start();
        send_word(32'd3);
        send_word(32'h11111111);
        send_byte(8'h22);
        send_byte(8'h33);
        bus.rx_data    = 8'hAA;
        bus.rx_valid   = 1'b1;
        bus.load_start = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(bus.rx_ready), 0);
        @(posedge clk);
        #1;
        bus.load_start = 1'b0;
        bus.rx_valid   = 1'b0;
        chk("abort_words", 32'(bus.words_loaded), 0);
        chk("abort_busy", 32'(bus.load_busy), 1);
        send_word(32'd1);
        send_word(32'hDEADBEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hDEADBEEF);
`endif
        cycles(2);
        chk("abort_run", 32'(bus.cpu_hold), 0);
        fetch_chk("abort_mem", 32'h0, 32'hDEADBEEF);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum, then good checksum
        expect_ev(1'b1, 2);
        pulse_start();
        send_word(32'd2);
        send_word(32'h12345678);
        send_word(32'h9ABCDEF0);
        send_word(32'hACF13569);
        cycles(3);
        chk("csum_bad_err", 32'(bus.load_err), 1);
        chk("csum_bad_hold", 32'(bus.cpu_hold), 1);
        expect_ev(1'b0, 2);
        pulse_start();
        send_word(32'd2);
        send_word(32'h12345678);
        send_word(32'h9ABCDEF0);
        send_word(32'hACF13568);
        cycles(2);
        chk("csum_good_hold", 32'(bus.cpu_hold), 0);
        chk("csum_good_err", 32'(bus.load_err), 0);
`endif

        cycles(5);
        chk("events_pending", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
